// File: rtl/seq_div_mod.sv
// Multicycle restoring divider (quotient + remainder) with a start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN to add the signedMode port for two's-complement operation.
module seq_div_mod #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic                 signedMode,
`endif
    output logic [OUT_WIDTH-1:0] quotient,
    output logic [OUT_WIDTH-1:0] remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic             zero_reg, zero_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             qext_reg, qext_next;
    logic             rext_reg, rext_next;
    logic             error_reg, error_next;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

`ifdef SEQ_DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic sgn_reg, sgn_next;
    logic negq_reg, negq_next;
    logic negr_reg, negr_next;
    logic ovf_reg, ovf_next;
    logic [WIDTH-1:0] q_fix, r_fix;
`endif

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        rem_next   = rem_reg;
        dvd_next   = dvd_reg;
        dvs_next   = dvs_reg;
        zero_next  = zero_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        qext_next  = qext_reg;
        rext_next  = rext_reg;
        error_next = error_reg;
`ifdef SEQ_DIV_SIGNED_EN
        sgn_next   = sgn_reg;
        negq_next  = negq_reg;
        negr_next  = negr_reg;
        ovf_next   = ovf_reg;
        q_fix      = '0;
        r_fix      = '0;
`endif
        // The dividend register shifts out its MSB and fills with quotient bits from the LSB.
        shifted  = {rem_reg, dvd_reg[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_reg};
        qbit     = ~trial[WIDTH];
        rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {dvd_reg[WIDTH-2:0], qbit};

        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    state_next = RUN;
                    error_next = 1'b0;
                    rem_next   = '0;
                    zero_next  = (inputB == '0);
                    // Divide-by-zero spends a single RUN cycle and then reports the error.
                    count_next = (inputB == '0) ? CW'(1) : CW'(WIDTH);
`ifdef SEQ_DIV_SIGNED_EN
                    sgn_next  = signedMode;
                    negq_next = signedMode & (inputA[WIDTH-1] ^ inputB[WIDTH-1]);
                    negr_next = signedMode & inputA[WIDTH-1];
                    ovf_next  = signedMode & (inputA == MIN_NEG) & (inputB == '1);
                    dvd_next  = (signedMode & inputA[WIDTH-1]) ? -inputA : inputA;
                    dvs_next  = (signedMode & inputB[WIDTH-1]) ? -inputB : inputB;
`else
                    dvd_next  = inputA;
                    dvs_next  = inputB;
`endif
                end
            end
            RUN: begin
                rem_next   = rem_step;
                dvd_next   = quo_step;
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                    if (zero_reg) begin
                        q_next     = '0;
                        r_next     = '0;
                        qext_next  = 1'b0;
                        rext_next  = 1'b0;
                        error_next = 1'b1;
                    end else begin
`ifdef SEQ_DIV_SIGNED_EN
                        q_fix      = negq_reg ? -quo_step : quo_step;
                        r_fix      = negr_reg ? -rem_step : rem_step;
                        q_next     = q_fix;
                        r_next     = r_fix;
                        qext_next  = sgn_reg & q_fix[WIDTH-1];
                        rext_next  = sgn_reg & r_fix[WIDTH-1];
                        error_next = ovf_reg;
`else
                        q_next     = quo_step;
                        r_next     = rem_step;
                        qext_next  = 1'b0;
                        rext_next  = 1'b0;
                        error_next = 1'b0;
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            zero_reg  <= 1'b0;
            q_reg     <= '0;
            r_reg     <= '0;
            qext_reg  <= 1'b0;
            rext_reg  <= 1'b0;
            error_reg <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sgn_reg   <= 1'b0;
            negq_reg  <= 1'b0;
            negr_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            rem_reg   <= rem_next;
            dvd_reg   <= dvd_next;
            dvs_reg   <= dvs_next;
            zero_reg  <= zero_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            qext_reg  <= qext_next;
            rext_reg  <= rext_next;
            error_reg <= error_next;
`ifdef SEQ_DIV_SIGNED_EN
            sgn_reg   <= sgn_next;
            negq_reg  <= negq_next;
            negr_reg  <= negr_next;
            ovf_reg   <= ovf_next;
`endif
        end
    end

    // Upper output bits replicate the extension bit (zero in unsigned mode).
    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_ext
            if (gi < WIDTH) begin : g_low
                assign quotient[gi]  = q_reg[gi];
                assign remainder[gi] = r_reg[gi];
            end else begin : g_high
                assign quotient[gi]  = qext_reg;
                assign remainder[gi] = rext_reg;
            end
        end
    endgenerate

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign error = error_reg;

endmodule

// File: tb/tb_seq_div_mod.sv
// Randomized and directed bench for seq_div_mod against a cycle-level arithmetic model.
module tb_seq_div_mod;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ina = '0;
    logic [15:0] inb = '0;
`ifdef SEQ_DIV_SIGNED_EN
    logic        sm_in = 1'b0;
`endif
    logic [31:0] quotient, remainder;
    logic        busy, done, error;

    int n_pass  = 0;
    int n_total = 0;

    seq_div_mod #(.WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .inputA(ina),
        .inputB(inb),
`ifdef SEQ_DIV_SIGNED_EN
        .signedMode(sm_in),
`endif
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Expected result of one division, straight from the arithmetic rules.
    function automatic void calc(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output logic e);
        int sa, sb;
        if (b == 16'd0) begin
            q = 32'd0; r = 32'd0; e = 1'b1;
        end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            q = 32'hFFFF8000; r = 32'd0; e = 1'b1;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
        end else begin
            q = {16'd0, a / b}; r = {16'd0, a % b}; e = 1'b0;
        end
    endfunction

    function automatic logic sm_eff();
`ifdef SEQ_DIV_SIGNED_EN
        return sm_in;
`else
        return 1'b0;
`endif
    endfunction

    // Model: outputs after the last edge, plus a pending operation with cycles left.
    logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic        m_e = 1'b0, p_e = 1'b0, m_done = 1'b0, m_pending = 1'b0;
    int          m_left = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("error", {31'd0, error}, {31'd0, m_e});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("busy", {31'd0, busy}, {31'd0, m_pending});
            if (rst) begin
                m_q = '0; m_r = '0; m_e = 1'b0; m_done = 1'b0; m_pending = 1'b0; m_left = 0;
            end else begin
                m_done = 1'b0;
                if (m_pending) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_q = p_q; m_r = p_r; m_e = p_e; m_done = 1'b1; m_pending = 1'b0;
                    end
                end else if (start) begin
                    calc(ina, inb, sm_eff(), p_q, p_r, p_e);
                    m_pending = 1'b1;
                    m_e = 1'b0;
                    m_left = (inb == 16'd0) ? 1 : 16;
                end
            end
        end
    end

    // Pulses start for one cycle; immediate=1 drives it in the current cycle.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s, input bit immediate);
        if (!immediate) begin
            @(posedge clk); #1;
        end
        start = 1'b1; ina = a; inb = b;
`ifdef SEQ_DIV_SIGNED_EN
        sm_in = s;
`else
        if (s) $display("note: signed request ignored in unsigned build");
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] q, output logic [31:0] r, output logic e, output int cyc);
        bit seen = 0;
        cyc = 0;
        q = '0; r = '0; e = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #2;
            cyc++;
            if (done) begin
                seen = 1; q = quotient; r = remainder; e = error;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        else $display("op done after %0d cycles: q=%h r=%h err=%0b", cyc, q, r, e);
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic s, input bit imm,
                            input logic [31:0] eq, input logic [31:0] er, input logic ee, input int ecyc);
        logic [31:0] q, r;
        logic e;
        int cyc;
        launch(a, b, s, imm);
        wait_done(q, r, e, cyc);
        chk("dir_q", q, eq);
        chk("dir_r", r, er);
        chk("dir_err", {31'd0, e}, {31'd0, ee});
        if (ecyc > 0) chk("dir_latency", 32'(cyc), 32'(ecyc));
    endtask

    initial begin
        logic [31:0] q, r;
        logic e;
        int cyc;
        logic [15:0] a, b;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);

        directed(16'd249, 16'd69, 1'b0, 0, 32'd3, 32'd42, 1'b0, 16);
        directed(16'd32000, 16'd16001, 1'b0, 0, 32'd1, 32'd15999, 1'b0, 16);
        directed(16'd65535, 16'd1, 1'b0, 1, 32'h0000FFFF, 32'd0, 1'b0, 16);
        directed(16'd5, 16'd0, 1'b0, 0, 32'd0, 32'd0, 1'b1, 1);
        launch(16'd10, 16'd3, 1'b0, 0);
        chk("err_cleared", {31'd0, error}, 32'd0);
        wait_done(q, r, e, cyc);
        chk("q_10_3", q, 32'd3);
        chk("r_10_3", r, 32'd1);
        chk("e_10_3", {31'd0, e}, 32'd0);

        launch(16'd1000, 16'd7, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ina = 16'($urandom); inb = 16'($urandom);
            start = (i == 4);
        end
        start = 1'b0;
        wait_done(q, r, e, cyc);
        chk("q_1000_7", q, 32'd142);
        chk("r_1000_7", r, 32'd6);
        chk("lat_1000_7", 32'(cyc), 32'd4);

        launch(16'd500, 16'd3, 1'b0, 0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_flags", {29'd0, busy, done, error}, 32'd0);
        repeat (20) @(posedge clk);
        directed(16'd9, 16'd4, 1'b0, 0, 32'd2, 32'd1, 1'b0, 16);

        directed(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'd1, 32'd0, 1'b0, 16);
        directed(16'd5, 16'd9, 1'b0, 0, 32'd0, 32'd5, 1'b0, 16);
        directed(16'd4321, 16'd1, 1'b0, 0, 32'd4321, 32'd0, 1'b0, 16);

`ifdef SEQ_DIV_SIGNED_EN
        directed(16'hFFF9, 16'd2, 1'b1, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 16);
        directed(16'h8000, 16'hFFFF, 1'b1, 0, 32'hFFFF8000, 32'd0, 1'b1, 16);
        directed(16'hFFF9, 16'd2, 1'b0, 0, 32'd32764, 32'd1, 1'b0, 16);
`endif

        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 15));
                2: b = 16'($urandom_range(1, 300));
                default: b = 16'($urandom);
            endcase
            launch(a, b, 1'($urandom_range(0, 1)), (n > 0) && ($urandom_range(0, 1) == 1));
            wait_done(q, r, e, cyc);
            chk("rnd_latency", 32'(cyc), (b == 16'd0) ? 32'd1 : 32'd16);
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
